// File: rtl/dram_noc_requester.sv
// NoC-side initiator for the DRAM controller: sends one load/store request packet on noc0 and consumes the response.
// Optional response-header checking is enabled by defining DRAM_NOC_REQUESTER_RESP_CHECK_EN.

`ifndef MSG_TYPE_LOAD_MEM
`define MSG_TYPE_LOAD_MEM 8'd19
`endif
`ifndef MSG_TYPE_STORE_MEM
`define MSG_TYPE_STORE_MEM 8'd20
`endif
`ifndef MSG_TYPE_LOAD_MEM_ACK
`define MSG_TYPE_LOAD_MEM_ACK 8'd24
`endif
`ifndef MSG_TYPE_STORE_MEM_ACK
`define MSG_TYPE_STORE_MEM_ACK 8'd25
`endif

module dram_noc_requester #(
    parameter int unsigned NOC_DATA_W = 512,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned NODE_ID_W  = 8,
    parameter int unsigned SRC_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_val,
    output logic                  req_rdy,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [NODE_ID_W-1:0]  req_dst,
    input  logic                  wr_data_val,
    input  logic [NOC_DATA_W-1:0] wr_data,
    output logic                  wr_data_rdy,
    output logic                  rd_data_val,
    output logic [NOC_DATA_W-1:0] rd_data,
    output logic                  rd_data_last,
    input  logic                  rd_data_rdy,
    output logic                  wr_done_val,
    input  logic                  wr_done_rdy,
    output logic                  requester_noc0_vrtoc_val,
    output logic [NOC_DATA_W-1:0] requester_noc0_vrtoc_data,
    input  logic                  noc0_vrtoc_requester_rdy,
    input  logic                  noc0_ctovr_requester_val,
    input  logic [NOC_DATA_W-1:0] noc0_ctovr_requester_data,
    output logic                  requester_noc0_ctovr_rdy,
    output logic                  resp_err
);
    localparam int unsigned BYTES_PER_FLIT = NOC_DATA_W / 8;
    localparam int unsigned TYPE_W  = 8;
    localparam int unsigned TYPE_LO = 2 * NODE_ID_W;
    localparam int unsigned MLEN_LO = TYPE_LO + TYPE_W;
    localparam int unsigned ADDR_LO = MLEN_LO + LEN_W;
    localparam int unsigned HDR_W   = ADDR_LO + ADDR_W + LEN_W;

    typedef enum logic [2:0] {
        IDLE, SEND_HDR, SEND_WR, WAIT_RESP_HDR, RECV_RD, WR_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [NOC_DATA_W-1:0] hdr_q;
    logic [LEN_W-1:0]      exp_flits_q, sent_cnt_q, recv_cnt_q, rx_len_q;
    logic                  is_write_q;

    logic [LEN_W:0]        len_round;
    logic [LEN_W-1:0]      exp_flits_new;
    logic [HDR_W-1:0]      hdr_new;
    logic [LEN_W-1:0]      rx_mlen;

    // ceil(req_len / BYTES_PER_FLIT) with one guard bit so the round-up cannot overflow
    assign len_round     = (LEN_W+1)'(req_len) + (LEN_W+1)'(BYTES_PER_FLIT - 1);
    assign exp_flits_new = LEN_W'(len_round / (LEN_W+1)'(BYTES_PER_FLIT));

    // Header layout, LSB first: dst, src, msg_type, msg_len, addr, data_size
    assign hdr_new = {req_len, req_addr,
                      req_write ? exp_flits_new : LEN_W'(0),
                      req_write ? `MSG_TYPE_STORE_MEM : `MSG_TYPE_LOAD_MEM,
                      NODE_ID_W'(SRC_ID), req_dst};

    assign rx_mlen = noc0_ctovr_requester_data[ADDR_LO-1:MLEN_LO];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            exp_flits_q <= '0;
            sent_cnt_q  <= '0;
            recv_cnt_q  <= '0;
            rx_len_q    <= '0;
            is_write_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_val) begin
                hdr_q       <= NOC_DATA_W'(hdr_new);
                exp_flits_q <= exp_flits_new;
                is_write_q  <= req_write;
                sent_cnt_q  <= '0;
                recv_cnt_q  <= '0;
            end
            if (state_q == SEND_WR && wr_data_val && noc0_vrtoc_requester_rdy)
                sent_cnt_q <= sent_cnt_q + LEN_W'(1);
            if (state_q == WAIT_RESP_HDR && noc0_ctovr_requester_val)
                rx_len_q <= rx_mlen;
            if (state_q == RECV_RD && noc0_ctovr_requester_val && rd_data_rdy)
                recv_cnt_q <= recv_cnt_q + LEN_W'(1);
        end
    end

    // Next state and outputs; everything is held low while rst is high
    always_comb begin
        state_d                   = state_q;
        req_rdy                   = 1'b0;
        wr_data_rdy               = 1'b0;
        rd_data_val               = 1'b0;
        rd_data                   = '0;
        rd_data_last              = 1'b0;
        wr_done_val               = 1'b0;
        requester_noc0_vrtoc_val  = 1'b0;
        requester_noc0_vrtoc_data = '0;
        requester_noc0_ctovr_rdy  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    req_rdy = 1'b1;
                    if (req_val) state_d = SEND_HDR;
                end
                SEND_HDR: begin
                    requester_noc0_vrtoc_val  = 1'b1;
                    requester_noc0_vrtoc_data = hdr_q;
                    if (noc0_vrtoc_requester_rdy)
                        state_d = (is_write_q && exp_flits_q != '0) ? SEND_WR : WAIT_RESP_HDR;
                end
                SEND_WR: begin
                    requester_noc0_vrtoc_val  = wr_data_val;
                    requester_noc0_vrtoc_data = wr_data;
                    wr_data_rdy               = noc0_vrtoc_requester_rdy;
                    if (wr_data_val && noc0_vrtoc_requester_rdy &&
                        sent_cnt_q == exp_flits_q - LEN_W'(1))
                        state_d = WAIT_RESP_HDR;
                end
                WAIT_RESP_HDR: begin
                    requester_noc0_ctovr_rdy = 1'b1;
                    if (noc0_ctovr_requester_val) begin
                        if (is_write_q)          state_d = WR_DONE;
                        else if (rx_mlen != '0)  state_d = RECV_RD;
                        else                     state_d = IDLE;
                    end
                end
                RECV_RD: begin
                    rd_data_val              = noc0_ctovr_requester_val;
                    rd_data                  = noc0_ctovr_requester_data;
                    requester_noc0_ctovr_rdy = rd_data_rdy;
                    rd_data_last             = (recv_cnt_q == rx_len_q - LEN_W'(1));
                    if (noc0_ctovr_requester_val && rd_data_rdy && rd_data_last)
                        state_d = IDLE;
                end
                WR_DONE: begin
                    wr_done_val = 1'b1;
                    if (wr_done_rdy) state_d = IDLE;
                end
                default: begin
                    state_d                   = state_t'(3'bxxx);
                    req_rdy                   = 1'bx;
                    wr_data_rdy               = 1'bx;
                    rd_data_val               = 1'bx;
                    rd_data                   = 'x;
                    rd_data_last              = 1'bx;
                    wr_done_val               = 1'bx;
                    requester_noc0_vrtoc_val  = 1'bx;
                    requester_noc0_vrtoc_data = 'x;
                    requester_noc0_ctovr_rdy  = 1'bx;
                end
            endcase
        end
    end

`ifdef DRAM_NOC_REQUESTER_RESP_CHECK_EN
    logic [NODE_ID_W-1:0] dst_q;
    logic [TYPE_W-1:0]    rx_type;
    logic [NODE_ID_W-1:0] rx_src;
    logic                 rx_bad;

    assign rx_type = noc0_ctovr_requester_data[MLEN_LO-1:TYPE_LO];
    assign rx_src  = noc0_ctovr_requester_data[TYPE_LO-1:NODE_ID_W];
    assign rx_bad  = (rx_type != (is_write_q ? `MSG_TYPE_STORE_MEM_ACK : `MSG_TYPE_LOAD_MEM_ACK)) ||
                     (rx_src != dst_q) ||
                     (!is_write_q && rx_mlen != exp_flits_q);

    // Sticky flag; the FSM keeps following the received msg_len regardless
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q    <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state_q == IDLE && req_val) dst_q <= req_dst;
            if (state_q == WAIT_RESP_HDR && noc0_ctovr_requester_val && rx_bad) begin
                resp_err <= 1'b1;
                $error("dram_noc_requester: bad response header type=%0d src=%0d len=%0d",
                       rx_type, rx_src, rx_mlen);
            end
        end
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_noc_requester.sv
// Self-checking bench for dram_noc_requester: vector table, randomized transactions against a packet-level model, reset/corner sequences.
module tb_dram_noc_requester;
    localparam int unsigned DW = 512;
    localparam logic [7:0] SRC         = 8'd0;
    localparam logic [7:0] T_LOAD      = 8'd19;
    localparam logic [7:0] T_STORE     = 8'd20;
    localparam logic [7:0] T_LOAD_ACK  = 8'd24;
    localparam logic [7:0] T_STORE_ACK = 8'd25;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_val, req_rdy, req_write;
    logic [63:0]   req_addr;
    logic [15:0]   req_len;
    logic [7:0]    req_dst;
    logic          wr_data_val, wr_data_rdy;
    logic [DW-1:0] wr_data;
    logic          rd_data_val, rd_data_last, rd_data_rdy;
    logic [DW-1:0] rd_data;
    logic          wr_done_val, wr_done_rdy;
    logic          tx_val, tx_rdy, rx_val, rx_rdy;
    logic [DW-1:0] tx_data, rx_data;
    logic          resp_err;

    int total = 0;
    int bad   = 0;

    dram_noc_requester #(
        .NOC_DATA_W(512), .ADDR_W(64), .LEN_W(16), .NODE_ID_W(8), .SRC_ID(0)
    ) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_dst(req_dst),
        .wr_data_val(wr_data_val), .wr_data(wr_data), .wr_data_rdy(wr_data_rdy),
        .rd_data_val(rd_data_val), .rd_data(rd_data), .rd_data_last(rd_data_last),
        .rd_data_rdy(rd_data_rdy),
        .wr_done_val(wr_done_val), .wr_done_rdy(wr_done_rdy),
        .requester_noc0_vrtoc_val(tx_val), .requester_noc0_vrtoc_data(tx_data),
        .noc0_vrtoc_requester_rdy(tx_rdy),
        .noc0_ctovr_requester_val(rx_val), .noc0_ctovr_requester_data(rx_data),
        .requester_noc0_ctovr_rdy(rx_rdy),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_hdr(input logic [7:0] d, input logic [7:0] s,
                                               input logic [7:0] t, input logic [15:0] ml,
                                               input logic [63:0] a, input logic [15:0] sz);
        logic [DW-1:0] h;
        h = '0;
        h[7:0]     = d;
        h[15:8]    = s;
        h[23:16]   = t;
        h[39:24]   = ml;
        h[103:40]  = a;
        h[119:104] = sz;
        return h;
    endfunction

    function automatic logic [DW-1:0] rand_flit();
        logic [DW-1:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = $urandom();
        return f;
    endfunction

    task automatic drive_idle();
        req_val = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_dst = '0;
        wr_data_val = 1'b0; wr_data = '0; rd_data_rdy = 1'b0; wr_done_rdy = 1'b0;
        tx_rdy = 1'b0; rx_val = 1'b0; rx_data = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_rdy"},  64'(req_rdy), 64'(0));
        chk({tag, "_tx_val"},   64'(tx_val), 64'(0));
        chkw({tag, "_tx_data"}, tx_data, '0);
        chk({tag, "_wr_rdy"},   64'(wr_data_rdy), 64'(0));
        chk({tag, "_rx_rdy"},   64'(rx_rdy), 64'(0));
        chk({tag, "_rd_val"},   64'(rd_data_val), 64'(0));
        chk({tag, "_rd_last"},  64'(rd_data_last), 64'(0));
        chk({tag, "_done_val"}, 64'(wr_done_val), 64'(0));
        chk({tag, "_resp_err"}, 64'(resp_err), 64'(0));
    endtask

    // One full request; starts at posedge+1 with the DUT idle, ends at posedge+1 after checking req_rdy recovery
    task automatic run_txn(input bit wr, input logic [63:0] addr, input logic [15:0] len,
                           input logic [7:0] dst, input int resp_mlen, input int tx_pct,
                           input int rx_pct, input int done_delay,
                           output int n_tx, output int n_rd, output int hdr_mlen);
        logic [DW-1:0] txq[$], wrq[$], rxq[$], rdq[$];
        logic [DW-1:0] f, prev_tx_data, prev_rd_data;
        int  nflit, wi, ri, tx_seen, rd_seen, done_wait;
        bit  accepted, done_seen, finished, cur_wv, cur_rv;
        bit  prev_tx_stall, prev_rd_stall, prev_done_stall;

        nflit = (int'(len) + 63) / 64;
        txq.push_back(make_hdr(dst, SRC, wr ? T_STORE : T_LOAD, wr ? 16'(nflit) : 16'(0), addr, len));
        if (wr) for (int i = 0; i < nflit; i++) begin
            f = rand_flit(); txq.push_back(f); wrq.push_back(f);
        end
        rxq.push_back(make_hdr(SRC, dst, wr ? T_STORE_ACK : T_LOAD_ACK, wr ? 16'(0) : 16'(resp_mlen), '0, '0));
        if (!wr) for (int i = 0; i < resp_mlen; i++) begin
            f = rand_flit(); rxq.push_back(f); rdq.push_back(f);
        end

        wi = 0; ri = 0; tx_seen = 0; rd_seen = 0; done_wait = 0; hdr_mlen = -1;
        accepted = 0; done_seen = 0; finished = 0; cur_wv = 0; cur_rv = 0;
        prev_tx_stall = 0; prev_rd_stall = 0; prev_done_stall = 0;
        prev_tx_data = '0; prev_rd_data = '0;

        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            req_val = !accepted; req_write = wr; req_addr = addr; req_len = len; req_dst = dst;
            if (wi < wrq.size()) begin
                if (!cur_wv) cur_wv = ($urandom_range(99) < 70);
            end else cur_wv = 0;
            wr_data_val = cur_wv;
            wr_data = cur_wv ? wrq[wi] : '0;
            tx_rdy = ($urandom_range(99) < 32'(tx_pct));
            if (!cur_rv) cur_rv = (tx_seen == txq.size()) && (ri < rxq.size()) && ($urandom_range(99) < 70);
            rx_val = cur_rv;
            rx_data = cur_rv ? rxq[ri] : '0;
            rd_data_rdy = ($urandom_range(99) < 32'(rx_pct));
            wr_done_rdy = (done_wait >= done_delay);

            @(negedge clk);
            if (prev_tx_stall) begin
                chk("tx_hold_val", 64'(tx_val), 64'(1));
                chkw("tx_hold_data", tx_data, prev_tx_data);
            end
            if (prev_rd_stall) begin
                chk("rd_hold_val", 64'(rd_data_val), 64'(1));
                chkw("rd_hold_data", rd_data, prev_rd_data);
            end
            if (prev_done_stall) chk("done_hold_val", 64'(wr_done_val), 64'(1));

            if (req_val && req_rdy) accepted = 1;
            if (tx_val && tx_rdy) begin
                if (tx_seen < txq.size()) chkw("tx_flit", tx_data, txq[tx_seen]);
                else chk("tx_count", 64'(tx_seen + 1), 64'(txq.size()));
                if (tx_seen == 0) hdr_mlen = int'(tx_data[39:24]);
                tx_seen++;
            end
            if (wr_data_val && wr_data_rdy) begin wi++; cur_wv = 0; end
            if (rx_val && rx_rdy) begin ri++; cur_rv = 0; end
            if (rd_data_val && rd_data_rdy) begin
                if (rd_seen < rdq.size()) begin
                    chkw("rd_flit", rd_data, rdq[rd_seen]);
                    chk("rd_last", 64'(rd_data_last), 64'(rd_seen == rdq.size() - 1));
                end else chk("rd_unexpected", 64'(rd_seen + 1), 64'(rdq.size()));
                rd_seen++;
            end
            if (wr_done_val) begin
                done_wait++;
                if (wr_done_rdy) done_seen = 1;
            end
            prev_tx_stall   = tx_val && !tx_rdy;
            prev_tx_data    = tx_data;
            prev_rd_stall   = rd_data_val && !rd_data_rdy;
            prev_rd_data    = rd_data;
            prev_done_stall = wr_done_val && !wr_done_rdy;
            finished = wr ? done_seen : (ri == rxq.size() && rd_seen == rdq.size());
            @(posedge clk); #1;
        end
        chk("txn_finished", 64'(finished), 64'(1));
        drive_idle();
        @(negedge clk);
        chk("req_rdy_after", 64'(req_rdy), 64'(1));
        chk("tx_total", 64'(tx_seen), 64'(txq.size()));
        @(posedge clk); #1;
        n_tx = tx_seen; n_rd = rd_seen;
    endtask

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [15:0] len;
        logic [7:0]  dst;
        int          resp_mlen;
        int          tx_pct;
        int          rx_pct;
        int          done_delay;
        int          exp_tx;
        int          exp_rd;
        int          exp_mlen;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   n_tx, n_rd, mlen, nflit, rlen;
        bit   w;
        logic [DW-1:0] p0;

        vecs[0] = '{1'b0, 64'h1000, 16'd200, 8'd3, 4,  100, 100, 0, 1, 4,  0};
        vecs[1] = '{1'b1, 64'h2000, 16'd128, 8'd5, 0,  100, 100, 3, 3, 0,  2};
        vecs[2] = '{1'b1, 64'h4000, 16'd640, 8'd7, 0,  50,  50,  1, 11, 0, 10};
        vecs[3] = '{1'b0, 64'h8000, 16'd640, 8'd7, 10, 50,  50,  0, 1, 10, 0};
        vecs[4] = '{1'b1, 64'h0040, 16'd0,   8'd2, 0,  100, 100, 2, 1, 0,  0};
        vecs[5] = '{1'b0, 64'h0080, 16'd0,   8'd2, 0,  100, 100, 0, 1, 0,  0};
        vecs[6] = '{1'b0, 64'h00c0, 16'd1,   8'd9, 1,  70,  70,  0, 1, 1,  0};
        vecs[7] = '{1'b1, 64'h0100, 16'd65,  8'd9, 0,  70,  70,  0, 3, 0,  2};

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_exit_req_rdy", 64'(req_rdy), 64'(1));
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].dst, vecs[v].resp_mlen,
                    vecs[v].tx_pct, vecs[v].rx_pct, vecs[v].done_delay, n_tx, n_rd, mlen);
            chk($sformatf("vec%0d_ntx", v), 64'(n_tx), 64'(vecs[v].exp_tx));
            chk($sformatf("vec%0d_nrd", v), 64'(n_rd), 64'(vecs[v].exp_rd));
            chk($sformatf("vec%0d_mlen", v), 64'(mlen), 64'(vecs[v].exp_mlen));
            chk($sformatf("vec%0d_err", v), 64'(resp_err), 64'(0));
        end

        for (int r = 0; r < 20; r++) begin
            w = 1'($urandom_range(1));
            rlen = int'($urandom_range(1200));
            nflit = (rlen + 63) / 64;
            run_txn(w, {32'($urandom()), 32'($urandom())}, 16'(rlen), 8'($urandom_range(255)),
                    w ? 0 : nflit, 50, 50, int'($urandom_range(3)), n_tx, n_rd, mlen);
            chk($sformatf("rnd%0d_ntx", r), 64'(n_tx), 64'(w ? nflit + 1 : 1));
            chk($sformatf("rnd%0d_nrd", r), 64'(n_rd), 64'(w ? 0 : nflit));
            chk($sformatf("rnd%0d_mlen", r), 64'(mlen), 64'(w ? nflit : 0));
        end

        // Reset during payload of a 3-flit store, after the first payload flit
        req_val = 1'b1; req_write = 1'b1; req_addr = 64'h5000; req_len = 16'd192; req_dst = 8'd6;
        tx_rdy = 1'b1;
        @(negedge clk);
        chk("rs_accept", 64'(req_rdy), 64'(1));
        @(posedge clk); #1;
        req_val = 1'b0;
        @(negedge clk);
        chkw("rs_hdr", tx_data, make_hdr(8'd6, SRC, T_STORE, 16'd3, 64'h5000, 16'd192));
        @(posedge clk); #1;
        p0 = rand_flit();
        wr_data_val = 1'b1; wr_data = p0;
        @(negedge clk);
        chkw("rs_flit0", tx_data, p0);
        chk("rs_flit0_rdy", 64'(wr_data_rdy), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rs_during");
        @(posedge clk); #1;
        rst = 1'b0;
        wr_data_val = 1'b0; wr_data = '0;
        @(negedge clk);
        chk("rs_req_rdy", 64'(req_rdy), 64'(1));
        chk("rs_tx_val", 64'(tx_val), 64'(0));
        @(posedge clk); #1;
        run_txn(1'b0, 64'h6000, 16'd256, 8'd3, 4, 80, 80, 0, n_tx, n_rd, mlen);
        chk("rs_load_nrd", 64'(n_rd), 64'(4));

`ifdef DRAM_NOC_REQUESTER_RESP_CHECK_EN
        run_txn(1'b0, 64'h3000, 16'd256, 8'd4, 3, 100, 100, 0, n_tx, n_rd, mlen);
        chk("chk_nrd", 64'(n_rd), 64'(3));
        chk("chk_err_set", 64'(resp_err), 64'(1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("chk_err_sticky", 64'(resp_err), 64'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
